// File: rtl/register_file_pkg.sv
// Shared types and defaults for the register_file block.
package register_file_pkg;

    // Write-port operation select.
    typedef enum logic [1:0] {
        WR_LOAD = 2'd0,
        WR_INC  = 2'd1,
        WR_DEC  = 2'd2,
        WR_CLR  = 2'd3
    } wr_op_t;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_NUM_REGS = 8;

endpackage

// File: rtl/register_file_reg_cell.sv
// reg_cell: one WIDTH-bit register with synchronous clear and write enable.
// Generalisation of the original 16-bit load register.
module reg_cell
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] value_reg;

    // Reset wins over write; otherwise load when selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= '0;
        end else if (write) begin
            value_reg <= in;
        end
    end

    assign out = value_reg;

endmodule

// File: rtl/register_file.sv
// register_file: NUM_REGS x WIDTH register bank, one write port with
// LOAD/INC/DEC/CLR ops, two combinational read ports and a registered
// wrap pulse for INC/DEC overflow.
// Optional build macro REGISTER_FILE_BYPASS_EN: write-through forwarding
// of the post-edge value onto read ports addressing the write target.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              wrap
);

    // One extra bit so NUM_REGS itself is representable for the range check.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    wr_op_t           op;
    logic             wr_valid;
    logic [WIDTH-1:0] cell_out [NUM_REGS];
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] wr_value_next;
    logic             wrap_next;
    logic             wrap_reg;

    assign op       = wr_op_t'(wr_op);
    assign wr_valid = wr_en && ({1'b0, wr_addr} < NUM_REGS_W);

    // Current contents of the write target; zero for out-of-range addresses.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                cur_val = cell_out[i];
            end
        end
    end

    // Single shared adder: +1 for INC, +all-ones (i.e. -1) for DEC.
    assign addend = (op == WR_DEC) ? '1 : WIDTH'(1);
    assign sum    = cur_val + addend;

    // Next value of the write target for the selected op.
    always_comb begin
        wr_value_next = '0;
        case (op)
            WR_LOAD: wr_value_next = wr_data;
            WR_INC:  wr_value_next = sum;
            WR_DEC:  wr_value_next = sum;
            WR_CLR:  wr_value_next = '0;
            default: wr_value_next = '0;
        endcase
    end

    // Wrap when INC leaves all-ones or DEC leaves zero on a valid write.
    assign wrap_next = wr_valid &&
                       (((op == WR_INC) && (cur_val == '1)) ||
                        ((op == WR_DEC) && (cur_val == '0)));

    // Wrap flag: one-cycle pulse per wrapping op, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wrap_next;
        end
    end

    assign wrap = wrap_reg;

    // Register cells; only the addressed cell is written.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
        reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .write (wr_valid && (wr_addr == ADDR_W'(gi))),
            .in    (wr_value_next),
            .out   (cell_out[gi])
        );
    end

    // Read port A: stored contents, optionally forwarded from the write port.
    always_comb begin
        rd_data_a = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = cell_out[i];
            end
        end
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_valid && !reset && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_value_next;
        end
`endif
    end

    // Read port B: stored contents, optionally forwarded from the write port.
    always_comb begin
        rd_data_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = cell_out[i];
            end
        end
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_valid && !reset && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_value_next;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file (NUM_REGS=6 so that addresses 6
// and 7 exercise the out-of-range path). Stimulus changes on negedge;
// results are checked before the next posedge (reads) or at the following
// negedge (wrap). Reference model: a plain array of register values.
module tb_register_file;
    import register_file_pkg::*;

    localparam int W  = 16;
    localparam int N  = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [1:0]    wr_op;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [W-1:0]  rd_data_a;
    logic [AW-1:0] rd_addr_b;
    logic [W-1:0]  rd_data_b;
    logic          wrap;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [W-1:0] model [N];
    logic         model_wrap = 1'b0;

    register_file #(
        .WIDTH    (W),
        .NUM_REGS (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_op     (wr_op),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wrap      (wrap)
    );

    always #20 clk = ~clk;

    // Value a register holds after applying op to cur.
    function automatic logic [W-1:0] after_op(input logic [1:0] op,
                                              input logic [W-1:0] cur,
                                              input logic [W-1:0] d);
        case (op)
            2'd0:    return d;
            2'd1:    return W'(cur + 1);
            2'd2:    return W'(cur - 1);
            default: return '0;
        endcase
    endfunction

    // What a read port should show right now, given current inputs.
    function automatic logic [W-1:0] expect_read(input logic [AW-1:0] a);
`ifdef REGISTER_FILE_BYPASS_EN
        if (!reset && wr_en && (wr_addr < N) && (a == wr_addr))
            return after_op(wr_op, model[wr_addr], wr_data);
`endif
        if (a < N) return model[a];
        return '0;
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [1:0] op,
                         input logic [AW-1:0] addr, input logic [W-1:0] d,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        reset = rst; wr_en = en; wr_op = op; wr_addr = addr; wr_data = d;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    // Clock one edge, advance the model, land on the following negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) model[i] = '0;
            model_wrap = 1'b0;
        end else if (wr_en && (wr_addr < N)) begin
            model_wrap = ((wr_op == 2'd1) && (model[wr_addr] == '1)) ||
                         ((wr_op == 2'd2) && (model[wr_addr] == '0));
            model[wr_addr] = after_op(wr_op, model[wr_addr], wr_data);
        end else begin
            model_wrap = 1'b0;
        end
        @(negedge clk);
        txn++;
        $display("txn %0d rst=%0b en=%0b op=%0d addr=%0d data=%h wrap=%0b",
                 txn, reset, wr_en, wr_op, wr_addr, wr_data, wrap);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 2'd0, 3'd0, 16'hFFFF, 3'd0, 3'd1);
        tick();
        wr_en = 1'b0; reset = 1'b0;
        for (int a = 0; a < N; a++) begin
            rd_addr_a = AW'(a); rd_addr_b = AW'(a); #1;
            checks++;
            if (rd_data_a !== 16'h0000) begin
                errors++; $display("FAIL reset_rd_a[%0d]: got %h expected 0000", a, rd_data_a);
            end
            checks++;
            if (rd_data_b !== 16'h0000) begin
                errors++; $display("FAIL reset_rd_b[%0d]: got %h expected 0000", a, rd_data_b);
            end
        end
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    endtask

    task automatic test_load_hold();
        drive(1'b0, 1'b1, 2'd0, 3'd3, 16'hABCD, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b1, 2'd0, 3'd5, 16'h1234, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b0, 2'd3, 3'd3, 16'h0000, 3'd3, 3'd5); tick(); tick();
        #1;
        checks++;
        if (rd_data_a !== 16'hABCD) begin errors++; $display("FAIL load_r3: got %h expected abcd", rd_data_a); end
        checks++;
        if (rd_data_b !== 16'h1234) begin errors++; $display("FAIL load_r5: got %h expected 1234", rd_data_b); end
        for (int a = 0; a < 5; a++) begin
            if (a == 3) continue;
            rd_addr_a = AW'(a); #1;
            checks++;
            if (rd_data_a !== 16'h0000) begin
                errors++; $display("FAIL load_other[%0d]: got %h expected 0000", a, rd_data_a);
            end
        end
    endtask

    task automatic test_inc_dec_wrap();
        drive(1'b0, 1'b1, 2'd0, 3'd2, 16'hFFFE, 3'd2, 3'd2); tick();
        drive(1'b0, 1'b1, 2'd1, 3'd2, 16'h0000, 3'd2, 3'd2); tick();
        wr_en = 1'b0; #1;
        checks++;
        if (rd_data_a !== 16'hFFFF || wrap !== 1'b0) begin
            errors++; $display("FAIL inc1: got %h/%b expected ffff/0", rd_data_a, wrap);
        end
        drive(1'b0, 1'b1, 2'd1, 3'd2, 16'h0000, 3'd2, 3'd2); tick();
        wr_en = 1'b0; #1;
        checks++;
        if (rd_data_a !== 16'h0000 || wrap !== 1'b1) begin
            errors++; $display("FAIL inc_wrap: got %h/%b expected 0000/1", rd_data_a, wrap);
        end
        drive(1'b0, 1'b1, 2'd2, 3'd2, 16'h0000, 3'd2, 3'd2); tick();
        wr_en = 1'b0; #1;
        checks++;
        if (rd_data_a !== 16'hFFFF || wrap !== 1'b1) begin
            errors++; $display("FAIL dec_wrap: got %h/%b expected ffff/1", rd_data_a, wrap);
        end
        drive(1'b0, 1'b0, 2'd0, 3'd2, 16'h0000, 3'd2, 3'd2); tick();
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse_end: got %b expected 0", wrap); end
    endtask

    task automatic test_read_during_write();
        logic [W-1:0] exp_v;
        drive(1'b0, 1'b1, 2'd0, 3'd3, 16'h1111, 3'd0, 3'd0); tick();
        drive(1'b0, 1'b1, 2'd0, 3'd3, 16'h5A5A, 3'd3, 3'd4); #1;
`ifdef REGISTER_FILE_BYPASS_EN
        exp_v = 16'h5A5A;
`else
        exp_v = 16'h1111;
`endif
        checks++;
        if (rd_data_a !== exp_v) begin errors++; $display("FAIL rdw_pre: got %h expected %h", rd_data_a, exp_v); end
        tick();
        wr_en = 1'b0; #1;
        checks++;
        if (rd_data_a !== 16'h5A5A) begin errors++; $display("FAIL rdw_post: got %h expected 5a5a", rd_data_a); end
        drive(1'b0, 1'b1, 2'd1, 3'd3, 16'h0000, 3'd0, 3'd3); #1;
`ifdef REGISTER_FILE_BYPASS_EN
        exp_v = 16'h5A5B;
`else
        exp_v = 16'h5A5A;
`endif
        checks++;
        if (rd_data_b !== exp_v) begin errors++; $display("FAIL rdw_inc_b: got %h expected %h", rd_data_b, exp_v); end
        wr_en = 1'b0;
    endtask

    task automatic test_invalid_addr();
        drive(1'b0, 1'b1, 2'd2, 3'd0, 16'h0000, 3'd0, 3'd0); tick();
        checks++;
        if (wrap !== 1'b1) begin errors++; $display("FAIL inv_setup_wrap: got %b expected 1", wrap); end
        drive(1'b0, 1'b1, 2'd0, 3'd7, 16'h7777, 3'd7, 3'd6); #1;
        checks++;
        if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL inv_rd7: got %h expected 0000", rd_data_a); end
        checks++;
        if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL inv_rd6: got %h expected 0000", rd_data_b); end
        tick();
        checks++;
        if (wrap !== 1'b0) begin errors++; $display("FAIL inv_wrap: got %b expected 0", wrap); end
        wr_en = 1'b0;
        for (int a = 0; a < N; a++) begin
            rd_addr_a = AW'(a); #1;
            checks++;
            if (rd_data_a !== model[a]) begin
                errors++; $display("FAIL inv_hold[%0d]: got %h expected %h", a, rd_data_a, model[a]);
            end
        end
    endtask

    task automatic test_clr_reset();
        drive(1'b0, 1'b1, 2'd0, 3'd4, 16'h00FF, 3'd4, 3'd4); tick();
        drive(1'b0, 1'b1, 2'd3, 3'd4, 16'hFFFF, 3'd4, 3'd4); tick();
        wr_en = 1'b0; #1;
        checks++;
        if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL clr: got %h expected 0000", rd_data_a); end
        drive(1'b0, 1'b1, 2'd0, 3'd4, 16'h0F0F, 3'd4, 3'd4); tick();
        drive(1'b1, 1'b1, 2'd0, 3'd4, 16'hABCD, 3'd4, 3'd2); #1;
        checks++;
        if (rd_data_a !== 16'h0F0F) begin errors++; $display("FAIL rst_no_fwd: got %h expected 0f0f", rd_data_a); end
        tick();
        reset = 1'b0; wr_en = 1'b0; #1;
        checks++;
        if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000 || wrap !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got %h/%h/%b expected 0000/0000/0", rd_data_a, rd_data_b, wrap);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                2:       d = 16'hFFFE;
                3:       d = 16'h0001;
                default: d = W'($urandom);
            endcase
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), d,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            #1;
            ea = expect_read(rd_addr_a);
            eb = expect_read(rd_addr_b);
            checks++;
            if (rd_data_a !== ea) begin errors++; $display("FAIL rand_rd_a #%0d: got %h expected %h", n, rd_data_a, ea); end
            checks++;
            if (rd_data_b !== eb) begin errors++; $display("FAIL rand_rd_b #%0d: got %h expected %h", n, rd_data_b, eb); end
            tick();
            checks++;
            if (wrap !== model_wrap) begin errors++; $display("FAIL rand_wrap #%0d: got %b expected %b", n, wrap, model_wrap); end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd0, 3'd0);
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_inc_dec_wrap();
        test_read_during_write();
        test_invalid_addr();
        test_clr_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
